// File: rtl/mmio_out_port.sv
// mmio_out_port: memory-mapped output port on the core's store bus.
// Stores to DATA are queued in a FIFO and drained over a valid/ready stream.
module mmio_out_port #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int unsigned DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [15:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd4;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic        hit_data, hit_stat;
    logic        empty, full;
    logic        pop, push, drop, clr;
    logic [31:0] status;

    // Byte-lane bits of the address play no part in the decode.
    logic        unused_addr;
    assign unused_addr = ^address[1:0];

    assign hit_data = (address[15:2] == BASE_ADDR[15:2]);
    assign hit_stat = (address[15:2] == STAT_ADDR[15:2]);

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A full FIFO can still take a word when the head leaves this cycle.
    assign pop  = out_valid && out_ready;
    assign push = WE && hit_data && (!full || pop);
    assign drop = WE && hit_data && full && !pop;
    assign clr  = WE && hit_stat && writeData[2];

    assign status = {16'h0, 8'(count_q), 5'h0, ovf_q, full, empty};

    assign out_valid = !empty;
    assign out_data  = out_valid ? mem_q[head_q] : 32'h0;
    assign overflow  = ovf_q;
    assign readData  = hit_stat ? status : 32'h0;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end
    end

    // Storage is not reset; a write in the reset cycle is suppressed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[tail_q] <= writeData;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_out_port.sv
// tb_mmio_out_port: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of the port.
module tb_mmio_out_port;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] STAT = 16'hFF04;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        WE;
    logic [15:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    always #5 clk = ~clk;

    mmio_out_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .WE        (WE),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    logic [31:0] q[$];
    bit m_ovf = 0;

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        int n;
        n = q.size();
        if (a[15:2] == BASE[15:2]) return 32'h0;
        if (a[15:2] == STAT[15:2])
            return {16'h0, 8'(n), 5'h0, m_ovf, (n == DEPTH), (n == 0)};
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: occupancy as a queue, applied at each rising edge.
    always @(posedge clk) begin
        bit pop_m;
        bit full_m;
        if (rst) begin
            q.delete();
            m_ovf = 0;
        end else begin
            pop_m  = (q.size() != 0) && out_ready;
            full_m = (q.size() == DEPTH);
            if (pop_m) void'(q.pop_front());
            if (WE && address[15:2] == BASE[15:2]) begin
                if (!full_m || pop_m) q.push_back(writeData);
                else m_ovf = 1;
            end else if (WE && address[15:2] == STAT[15:2] && writeData[2]) begin
                m_ovf = 0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
            chk("m_data", out_data, (q.size() != 0) ? q[0] : 32'h0);
            chk("m_ovf", {31'h0, overflow}, {31'h0, m_ovf});
            chk("m_rdata", readData, exp_rd(address));
        end
    end

    task automatic cyc(input bit r, input bit w, input logic [15:0] a,
                       input logic [31:0] d, input bit rdy);
        rst = r;
        WE = w;
        address = a;
        writeData = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string nm, input logic [15:0] a,
                          input logic [31:0] exp);
        WE = 1'b0;
        address = a;
        #1;
        chk(nm, readData, exp);
    endtask

    logic [15:0] addrs [8];

    initial begin
        addrs = '{16'hFF00, 16'hFF01, 16'hFF03, 16'hFF00,
                  16'hFF04, 16'hFF06, 16'h0040, 16'hFF08};

        cyc(1, 0, 16'h0, 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        rst = 1'b0;
        chk_en = 1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk_rd("rst_status", 16'hFF04, 32'h0000_0001);
        chk_rd("rst_other", 16'h0040, 32'h0);

        cyc(0, 1, BASE, 32'hDEAD_BEEF, 0);
        chk("single_valid", {31'h0, out_valid}, 32'h1);
        chk("single_data", out_data, 32'hDEAD_BEEF);
        chk_rd("single_status", 16'hFF04, 32'h0000_0100);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 16'h0, 0, 0);
            chk("hold_data", out_data, 32'hDEAD_BEEF);
        end
        cyc(0, 0, 16'h0, 0, 1);
        chk("single_drained", {31'h0, out_valid}, 32'h0);

        for (int i = 1; i <= 8; i++) cyc(0, 1, BASE, i, 0);
        chk_rd("full_status", 16'hFF04, 32'h0000_0802);
        cyc(0, 1, BASE, 9, 0);
        chk("drop_ovf", {31'h0, overflow}, 32'h1);
        chk_rd("drop_status", 16'hFF04, 32'h0000_0806);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", out_data, i);
            cyc(0, 0, 16'h0, 0, 1);
        end
        chk("drain_empty", {31'h0, out_valid}, 32'h0);

        cyc(0, 1, 16'hFF06, 32'h4, 0);
        chk("clr_ovf", {31'h0, overflow}, 32'h0);

        for (int i = 1; i <= 8; i++) cyc(0, 1, BASE, i, 0);
        cyc(0, 1, BASE, 32'h63, 1);
        chk("pp_head", out_data, 32'h2);
        chk("pp_ovf", {31'h0, overflow}, 32'h0);
        chk_rd("pp_status", 16'hFF04, 32'h0000_0802);
        for (int i = 2; i <= 9; i++) begin
            chk("pp_drain", out_data, (i == 9) ? 32'h63 : i);
            cyc(0, 0, 16'h0, 0, 1);
        end
        chk("pp_empty", {31'h0, out_valid}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, BASE, 32'd100 + i, 1);
            chk("stream_data", out_data, 32'd100 + i);
        end
        cyc(0, 0, 16'h0, 0, 1);
        chk("stream_empty", {31'h0, out_valid}, 32'h0);

        for (int i = 0; i < 600; i++) begin
            bit r;
            bit w;
            bit rdy;
            r = ($urandom_range(0, 79) == 0);
            w = ($urandom_range(0, 2) != 0);
            rdy = (i < 250) ? ($urandom_range(0, 3) == 0)
                            : ($urandom_range(0, 1) == 1);
            cyc(r, w, addrs[$urandom_range(0, 7)], $urandom, rdy);
        end

        cyc(0, 0, 16'h0, 0, 1);
        cyc(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, BASE, 32'hA0 + i, 0);
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        cyc(1, 1, BASE, 32'h77, 1);
        rst = 1'b0;
        chk("midrst_valid", {31'h0, out_valid}, 32'h0);
        chk_rd("midrst_status", 16'hFF04, 32'h0000_0001);
        cyc(0, 0, 16'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_out_port.md
# mmio_out_port

Memory-mapped output port that responds to the rv32i core's data-store bus (`WE`/`address`/`writeData`/`readData`) alongside the main memory. Stores to its data register are buffered in a FIFO and drained to an external consumer over a valid/ready stream. A status register lets software poll FIFO state before writing. The block sits in the top level in parallel with `mem`. The top muxes `readData` by address window.

## Interface
- `BASE_ADDR`, 16'hFF00: byte address of the DATA register. STATUS is at `BASE_ADDR+4`. Bits [2:0] must be 0.
- `DEPTH`, 8: FIFO entries. Must be a power of 2, at least 2.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `WE`, input, 1: store strobe from the core.
- `address`, input, 16: byte address from the core.
- `writeData`, input, 32: store data from the core.
- `readData`, output, 32: load data for a hit in the port's window. 0 otherwise.
- `out_data`, output, 32: FIFO head word.
- `out_valid`, output, 1: head word is valid.
- `out_ready`, input, 1: consumer accepts the head this cycle.
- `overflow`, output, 1: sticky flag, set when a store to DATA was dropped.

## Operation
- **Address decode.** Compare `address[15:2]` with `BASE_ADDR[15:2]`; a match hits DATA. Compare `address[15:2]` with `(BASE_ADDR+4)[15:2]`; a match hits STATUS. `address[1:0]` is ignored.
- **Push.** Occurs when `WE` is high, DATA is hit, and the FIFO is not full, or is full and a pop happens in the same cycle. `writeData` is written at the tail and the tail pointer advances.
- **Dropped store.** `WE` with a DATA hit while full and no pop: the word is discarded and `overflow` is set to 1.
- **Pop.** `out_valid && out_ready`: the head pointer advances.
- **Count.** `count` is `$clog2(DEPTH)+1` bits and tracks occupancy:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- **Pointers.** Head and tail are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- **STATUS read value** (combinational): bit0 = empty, bit1 = full, bit2 = overflow, bits[15:8] = count zero-extended, all other bits 0.
- **Write to STATUS.** If `writeData[2]=1`, `overflow` is cleared. Otherwise there is no effect. If a clear and a drop happen in the same cycle, set wins. In practice this cannot happen, because both require a single address.
- **Read of DATA.** Returns 0 and has no side effect. Reads never pop.
- **`readData`** is combinational from `address` and current state. It is 0 when neither register is hit.
- **Stream outputs.** `out_valid` = (count != 0). `out_data` = head entry when `out_valid` is 1, and 0 otherwise.
- **Ordering.** Strictly FIFO. No word is duplicated or reordered.

## Timing
- **Reset** (synchronous, `rst` high at an edge):
  - Head, tail and count = 0, `overflow` = 0.
  - `out_valid` = 0, `out_data` = 0.
  - STATUS reads 32'h0000_0001.
  - FIFO storage contents need not be cleared.
- **Reset mid-operation.** All buffered words are discarded. Any push or pop in the reset cycle is ignored.
- **Store-to-output latency.** 1 cycle. A store at edge N makes `out_valid` high after edge N when the FIFO was empty.
- **Stream handshake.**
  - `out_valid` never drops without a pop.
  - `out_data` is stable while `out_valid && !out_ready`.
  - `out_ready` may be asserted with `out_valid` low; this has no effect.
- **Full/empty.** Full = (count == DEPTH). Empty = (count == 0). Both reflect post-edge state.
- **Simultaneous push and pop:**
  - Empty FIFO: push only, since `out_valid` is 0.
  - Full FIFO: both accepted, count stays at DEPTH, no overflow.
- **STATUS read after a store.** Reflects the store from the next cycle onward.

## Test plan
- **Reset and idle.** Assert `rst` for 2 cycles, then write nothing.
  - After reset: `out_valid`=0, `out_data`=0, `overflow`=0.
  - Read at 16'hFF04 returns 32'h0000_0001.
  - Read at 16'h0040 returns 0.
- **Single store.** Store 32'hDEAD_BEEF to 16'hFF00 with `out_ready`=0.
  - Next cycle: `out_valid`=1, `out_data`=DEAD_BEEF.
  - STATUS = 32'h0000_0100.
  - Hold `out_ready`=0 for 5 cycles: output unchanged.
- **Fill and drop.** Store 1..9 to 16'hFF00 with `out_ready`=0, DEPTH=8.
  - After store 8: STATUS = 32'h0000_0802.
  - After store 9: `overflow`=1 and STATUS = 32'h0000_0806.
  - Drain with `out_ready`=1: outputs 1..8 on consecutive cycles, never 9.
  - Afterwards: `out_valid`=0.
- **Full with simultaneous push and pop.** Start with the FIFO full of 1..8 and `out_ready`=1, then store 32'h0000_0063 in the same cycle.
  - 1 pops, 0x63 is accepted, count stays 8, `overflow` stays 0.
  - Drain order is 2..8 then 0x63.
- **Overflow clear and wrap-around.**
  - Write 32'h4 to 16'hFF06: `overflow`=0. The low address bits are ignored, so this hits STATUS.
  - Stream 20 stores with `out_ready`=1 every cycle: all 20 values emerge in order, with pointers wrapping twice.
- **Reset mid-operation.** Store 3 words, pulse `rst` for 1 cycle while also asserting a store and `out_ready`.
  - Next cycle: `out_valid`=0 and STATUS = 32'h0000_0001.
